crc32_stream: RTL and testbench
===============================

CRC32_STREAM -- requirements
Module: crc32_stream

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
- DATA_BYTES, 1, bytes per beat; legal values 1, 2, 4, 8.
- LEN_W, 16, width of the frame byte counter.
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, reset; synchronous, active-high.
- s_valid, in, 1, input beat valid.
- s_ready, out, 1, block accepts beat; beat transfers when s_valid & s_ready.
- s_data, in, 8*DATA_BYTES, beat data; lane [7:0] = first byte on wire.
- s_keep, in, DATA_BYTES, byte enables; honoured on last beat only.
- s_last, in, 1, final beat of frame.
- s_abort, in, 1, discard current frame (sampled when s_valid & s_ready).
- crc_valid, out, 1, one-cycle pulse: result fields valid.
- crc_out, out, 32, final FCS = bitwise NOT of CRC register.
- fcs_ok, out, 1, CRC register equals residue 32'hDEBB20E3.
- frame_len, out, LEN_W, bytes processed in the reported frame.
- busy, out, 1, high while a frame is open (state ACC).

Function
REQ-003 SHALL compute IEEE 802.3 CRC-32: reflected polynomial 32'hEDB88320, LSB-first per byte, register initialised to 32'hFFFFFFFF.
REQ-004 SHALL process all enabled bytes of one beat in a single cycle; lanes are applied in order lane 0 first.
REQ-005 SHALL implement the states IDLE, ACC and DONE.
REQ-006 In IDLE, an accepted beat SHALL start a frame from INIT (no explicit start input) and SHALL go to ACC, or to DONE if s_last=1.
REQ-007 In ACC, each accepted beat SHALL update the CRC register; s_last=1 SHALL go to DONE.
REQ-008 DONE SHALL last exactly one cycle, during which:
- s_ready=0.
- crc_valid=1.
- crc_out, fcs_ok and frame_len reflect the frame just completed.
- next state is IDLE.
REQ-009 Latency: last beat accepted at cycle N -> crc_valid high in cycle N+1; the next beat can be accepted in cycle N+2.
REQ-010 s_ready SHALL be 1 in IDLE and ACC and 0 in DONE and during reset.
REQ-011 On non-last beats, s_keep SHALL be ignored and all DATA_BYTES lanes processed.
REQ-012 On the last beat, only the contiguous run of set s_keep bits starting at bit 0 SHALL be processed; lanes at and above the first zero are dropped.
REQ-013 A last beat with s_keep[0]=0 SHALL contribute no bytes but SHALL still close the frame.
REQ-014 frame_len SHALL count processed bytes, saturate at all ones, and restart at 0 for each frame.
REQ-015 crc_out, fcs_ok and frame_len SHALL hold their last reported values until the next DONE.
REQ-016 Abort: an accepted beat with s_abort=1 SHALL discard the frame and go to IDLE with no crc_valid and outputs unchanged.
REQ-017 If s_abort and s_last are both set on the same beat, abort SHALL win.
REQ-018 s_valid=0 in ACC SHALL hold the CRC register and byte count unchanged (gaps allowed).
REQ-019 fcs_ok SHALL be meaningful when the frame includes its received FCS; on TX frames it is don't-care.

Reset
REQ-020 While rst=1 the block SHALL be in IDLE with:
- CRC register = 32'hFFFFFFFF.
- crc_valid=0, busy=0, s_ready=0.
- crc_out=32'h0, fcs_ok=0, frame_len=0.
REQ-021 Asserting rst mid-frame SHALL discard the frame with no crc_valid; the first beat after reset release SHALL start a new frame.

Verification
REQ-022 DATA_BYTES=1, ASCII "123456789" (9 beats, last on '9') -> crc_valid one cycle after last, crc_out=32'hCBF43926, frame_len=9.
REQ-023 DATA_BYTES=4, same string as 3 beats with last s_keep=4'b0001 -> crc_out=32'hCBF43926, frame_len=9.
REQ-024 DATA_BYTES=4, "123456789" followed by FCS bytes 26 39 F4 CB (13 bytes, last keep=4'b0001) -> fcs_ok=1, frame_len=13; flip any one data bit -> fcs_ok=0.
REQ-025 Abort mid-frame, then send "123456789" -> exactly one crc_valid, crc_out=32'hCBF43926; repeat with s_abort and s_last together -> no crc_valid.
REQ-026 Back-to-back frames with random s_valid gaps, plus rst asserted mid-frame -> s_ready=0 only in DONE and reset, results match a software model, all outputs at reset values after rst.

Source files
------------

// File: rtl/crc32_stream.sv
// ---------------------------------------------------------------------------
// crc32_stream
//
// Streaming IEEE 802.3 CRC-32 (reflected poly 0xEDB88320, init all ones,
// LSB-first per byte). It processes up to DATA_BYTES bytes per accepted beat
// in one cycle, with lane 0 applied first. A frame opens on the first
// accepted beat and closes on s_last. For one cycle (DONE) the block then
// reports the FCS, the residue check and the byte count.
//
// Handshake: a beat transfers on a rising edge where s_valid & s_ready.
// s_ready is high in IDLE and ACC. It is low in DONE and while rst is high.
// s_valid may be dropped between beats at any time, and the frame state
// holds across such gaps.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   s_valid/s_ready  beat handshake
//   s_data           beat data, lane [7:0] is first byte on the wire
//   s_keep           byte enables, only looked at on the last beat
//   s_last           final beat of frame
//   s_abort          drop the open frame (wins over s_last)
//   crc_valid        one-cycle result pulse
//   crc_out          final FCS (inverted CRC register)
//   fcs_ok           CRC register equals the good-frame residue
//   frame_len        processed byte count, saturating
//   busy             frame open (state ACC)
//   fsm_state        current FSM state for debug/checkers
// ---------------------------------------------------------------------------
module crc32_stream #(
    parameter int DATA_BYTES = 1,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_last,
    input  logic                    s_abort,
    output logic                    crc_valid,
    output logic [31:0]             crc_out,
    output logic                    fcs_ok,
    output logic [LEN_W-1:0]        frame_len,
    output logic                    busy,
    output logic [1:0]              fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0]      POLY    = 32'hEDB88320;
    localparam logic [31:0]      INIT    = 32'hFFFFFFFF;
    localparam logic [31:0]      RESIDUE = 32'hDEBB20E3;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state;
    logic [31:0]      crc_reg;
    logic [LEN_W-1:0] len_reg;

    logic                  accept;
    logic [DATA_BYTES-1:0] lane_en;
    logic [31:0]           crc_base;
    logic [31:0]           crc_next;
    logic [LEN_W-1:0]      len_base;
    logic [LEN_W:0]        nbytes;
    logic [LEN_W:0]        len_sum;
    logic [LEN_W-1:0]      len_next;
    logic                  run;

    // One byte through the bit-serial reflected CRC, unrolled by synthesis.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ d[k]) r = (r >> 1) ^ POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign s_ready   = !rst && (state != DONE);
    assign accept    = s_valid && s_ready;
    assign fsm_state = state;

    always_comb begin
        lane_en  = '0;
        nbytes   = '0;
        run      = 1'b1;
        // A beat seen in IDLE opens a new frame, so it starts from INIT.
        crc_base = (state == ACC) ? crc_reg : INIT;
        len_base = (state == ACC) ? len_reg : '0;
        crc_next = crc_base;
        for (int i = 0; i < DATA_BYTES; i++) begin
            // On the last beat, stop at the first cleared keep bit.
            // On other beats, every lane counts.
            run        = run & (s_keep[i] | !s_last);
            lane_en[i] = run;
            if (lane_en[i]) begin
                crc_next = crc_byte(crc_next, s_data[8*i +: 8]);
                nbytes   = nbytes + {{LEN_W{1'b0}}, 1'b1};
            end
        end
        len_sum  = {1'b0, len_base} + nbytes;
        len_next = len_sum[LEN_W] ? LEN_MAX : len_sum[LEN_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            len_reg   <= '0;
            crc_valid <= 1'b0;
            busy      <= 1'b0;
            crc_out   <= 32'h0;
            fcs_ok    <= 1'b0;
            frame_len <= '0;
        end else begin
            crc_valid <= 1'b0;
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        if (s_abort) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            crc_reg <= INIT;
                            len_reg <= '0;
                        end else if (s_last) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            crc_valid <= 1'b1;
                            crc_out   <= ~crc_next;
                            fcs_ok    <= (crc_next == RESIDUE);
                            frame_len <= len_next;
                            crc_reg   <= INIT;
                            len_reg   <= '0;
                        end else begin
                            state   <= ACC;
                            busy    <= 1'b1;
                            crc_reg <= crc_next;
                            len_reg <= len_next;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_stream.sv
// ---------------------------------------------------------------------------
// tb_crc32_stream
//
// Bench for crc32_stream with two instances:
//   u_dut1: DATA_BYTES=1 with a 4-bit length counter, so saturation is
//           reachable.
//   u_dut4: DATA_BYTES=4 with a 16-bit length counter.
//
// The stimulus side pushes the expected {crc_out, fcs_ok, frame_len} into a
// per-instance queue. A monitor pops and compares it on every crc_valid.
// Directed vectors use hand-computed results. Random frames use a small
// bit-serial reference model.
// ---------------------------------------------------------------------------
module tb_crc32_stream;

    localparam int EW = 49;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_valid1, s_ready1, s_last1, s_abort1;
    logic [7:0]  s_data1;
    logic [0:0]  s_keep1;
    logic        crc_valid1, fcs_ok1, busy1;
    logic [31:0] crc_out1;
    logic [3:0]  frame_len1;
    logic [1:0]  fsm_state1;

    logic        s_valid4, s_ready4, s_last4, s_abort4;
    logic [31:0] s_data4;
    logic [3:0]  s_keep4;
    logic        crc_valid4, fcs_ok4, busy4;
    logic [31:0] crc_out4;
    logic [15:0] frame_len4;
    logic [1:0]  fsm_state4;

    crc32_stream #(.DATA_BYTES(1), .LEN_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_data(s_data1), .s_keep(s_keep1), .s_last(s_last1), .s_abort(s_abort1),
        .crc_valid(crc_valid1), .crc_out(crc_out1), .fcs_ok(fcs_ok1),
        .frame_len(frame_len1), .busy(busy1), .fsm_state(fsm_state1)
    );

    crc32_stream #(.DATA_BYTES(4), .LEN_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid4), .s_ready(s_ready4),
        .s_data(s_data4), .s_keep(s_keep4), .s_last(s_last4), .s_abort(s_abort4),
        .crc_valid(crc_valid4), .crc_out(crc_out4), .fcs_ok(fcs_ok4),
        .frame_len(frame_len4), .busy(busy4), .fsm_state(fsm_state4)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp1_q[$];
    logic [EW-1:0] exp4_q[$];
    logic [7:0]    fb[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference CRC register over fb[0..n-1], before the final inversion.
    function automatic logic [31:0] model_reg(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ fb[i][k]) c = (c >> 1) ^ 32'hEDB88320;
                else                 c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic push_exp(input bit w4, input logic [31:0] crc, input bit ok, input logic [15:0] len);
        if (w4) exp4_q.push_back({crc, ok, len});
        else    exp1_q.push_back({crc, ok, len});
    endtask

    task automatic push_model(input bit w4, input int n);
        logic [31:0] r;
        int lim;
        r   = model_reg(n);
        lim = w4 ? 65535 : 15;
        push_exp(w4, ~r, (r == 32'hDEBB20E3), 16'((n > lim) ? lim : n));
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) fb[i] = s[i];
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until it is accepted.
    // Inputs change 1 time unit after a rising edge.
    task automatic beat(input bit w4, input logic [31:0] data, input logic [3:0] keep,
                        input bit last, input bit abort);
        bit ok;
        int waits;
        waits = 0;
        if (w4) begin
            s_valid4 = 1'b1; s_data4 = data; s_keep4 = keep; s_last4 = last; s_abort4 = abort;
        end else begin
            s_valid1 = 1'b1; s_data1 = data[7:0]; s_keep1 = keep[0]; s_last1 = last; s_abort1 = abort;
        end
        do begin
            @(negedge clk);
            ok = w4 ? s_ready4 : s_ready1;
            @(posedge clk);
            #1;
            waits++;
        end while (!ok && waits < 20);
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: got no s_ready expected accept within 20 cycles");
        end
        if (w4) s_valid4 = 1'b0;
        else    s_valid1 = 1'b0;
        if (ok && last && !abort) begin
            check("latency_crc_valid", w4 ? crc_valid4 : crc_valid1, 1);
            check("done_s_ready", w4 ? s_ready4 : s_ready1, 0);
        end
    endtask

    // Send fb[0..n-1] as one frame. Keep bits on non-last beats are random.
    // On the last beat, garbage keep bits sit above the first zero.
    task automatic send_frame(input bit w4, input int n, input bit gaps);
        int bpb, nb, r, kr, junk, msk, idx;
        logic [31:0] data;
        logic [3:0]  keep;
        bit last;
        bpb = w4 ? 4 : 1;
        msk = w4 ? 15 : 1;
        nb  = (n == 0) ? 1 : (n + bpb - 1) / bpb;
        for (int b = 0; b < nb; b++) begin
            data = $urandom;
            for (int l = 0; l < bpb; l++) begin
                idx = b * bpb + l;
                if (idx < n) data[8*l +: 8] = fb[idx];
            end
            last = (b == nb - 1);
            if (last) begin
                r    = n - b * bpb;
                kr   = (1 << r) - 1;
                junk = int'($urandom) & ~((1 << (r + 1)) - 1);
                keep = 4'((kr | junk) & msk);
            end else begin
                keep = 4'($urandom);
            end
            beat(w4, data, keep, last, 1'b0);
            if (gaps) gap($urandom_range(0, 2));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_crc_out1"}, crc_out1, 0);
        check({tag, "_fcs_ok1"}, fcs_ok1, 0);
        check({tag, "_frame_len1"}, frame_len1, 0);
        check({tag, "_busy1"}, busy1, 0);
        check({tag, "_state1"}, fsm_state1, 0);
        check({tag, "_crc_out4"}, crc_out4, 0);
        check({tag, "_fcs_ok4"}, fcs_ok4, 0);
        check({tag, "_frame_len4"}, frame_len4, 0);
        check({tag, "_busy4"}, busy4, 0);
        check({tag, "_crc_valid4"}, crc_valid4, 0);
        check({tag, "_s_ready4"}, s_ready4, 0);
    endtask

    // Monitors: results are compared when presented, and s_ready is checked
    // against reset every cycle.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) check("rst_s_ready1", s_ready1, 0);
        else if (!crc_valid1) check("open_s_ready1", s_ready1, 1);
        if (crc_valid1) begin
            if (exp1_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid1: got crc_valid with crc %h expected none", crc_out1);
            end else begin
                e = exp1_q.pop_front();
                check("crc_out1", crc_out1, e[48:17]);
                check("fcs_ok1", fcs_ok1, e[16]);
                check("frame_len1", frame_len1, e[15:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) check("rst_s_ready4", s_ready4, 0);
        else if (!crc_valid4) check("open_s_ready4", s_ready4, 1);
        if (crc_valid4) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid4: got crc_valid with crc %h expected none", crc_out4);
            end else begin
                e = exp4_q.pop_front();
                check("crc_out4", crc_out4, e[48:17]);
                check("fcs_ok4", fcs_ok4, e[16]);
                check("frame_len4", frame_len4, e[15:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        s_valid1 = 0; s_data1 = 0; s_keep1 = 0; s_last1 = 0; s_abort1 = 0;
        s_valid4 = 0; s_data4 = 0; s_keep4 = 0; s_last4 = 0; s_abort4 = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_crc_valid1", crc_valid1, 0);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        gap(1);

        // Byte-wide instance
        load_str("123456789");
        push_exp(0, 32'hCBF43926, 0, 9);
        send_frame(0, 9, 1);
        load_str("a");
        push_exp(0, 32'hE8B7BE43, 0, 1);
        send_frame(0, 1, 0);
        push_exp(0, 32'h00000000, 0, 0);        // keep[0]=0: empty frame
        send_frame(0, 0, 0);
        fill_rand(20);
        push_model(0, 20);                      // length saturates at 15
        send_frame(0, 20, 1);

        // Word-wide instance
        load_str("123456789");
        push_exp(1, 32'hCBF43926, 0, 9);
        send_frame(1, 9, 1);
        gap(4);
        check("hold_crc_out4", crc_out4, 32'hCBF43926);
        check("hold_frame_len4", frame_len4, 9);

        // Data plus its own FCS gives the residue
        fb[9] = 8'h26; fb[10] = 8'h39; fb[11] = 8'hF4; fb[12] = 8'hCB;
        push_exp(1, 32'h2144DF1C, 1, 13);
        send_frame(1, 13, 0);
        fb[0] = fb[0] ^ 8'h01;
        begin
            logic [31:0] r;
            r = model_reg(13);
            push_exp(1, ~r, 0, 13);
        end
        send_frame(1, 13, 1);

        // Non-contiguous keep: lane 2 is dropped behind the cleared lane 1
        push_exp(1, 32'hCBF43926, 0, 9);
        beat(1, 32'h34333231, 4'hF, 0, 0);
        beat(1, 32'h38373635, 4'h0, 0, 0);
        beat(1, 32'hAA55AA39, 4'b0101, 1, 0);
        push_exp(1, 32'h00000000, 0, 0);
        beat(1, 32'hDEADBEEF, 4'b1110, 1, 0);

        // Abort mid-frame, then a clean frame
        beat(1, 32'h34333231, 4'hF, 0, 0);
        check("mid_busy4", busy4, 1);
        check("mid_state4", fsm_state4, 1);
        beat(1, 32'h38373635, 4'hF, 0, 1);
        check("abort_busy4", busy4, 0);
        check("abort_crc_out4", crc_out4, 32'h00000000);
        load_str("123456789");
        push_exp(1, 32'hCBF43926, 0, 9);
        send_frame(1, 9, 0);
        // Abort together with last: no result
        beat(1, 32'h34333231, 4'hF, 0, 0);
        beat(1, 32'h38373635, 4'hF, 0, 0);
        beat(1, 32'h00000039, 4'h1, 1, 1);
        beat(1, 32'h12345678, 4'hF, 1, 1);
        gap(3);
        check("abort_hold_crc4", crc_out4, 32'hCBF43926);
        check("abort_hold_len4", frame_len4, 9);

        // Random back-to-back frames with gaps
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 16);
            fill_rand(n);
            push_model(1, n);
            send_frame(1, n, 1);
        end
        for (int f = 0; f < 2; f++) begin
            int n;
            n = $urandom_range(1, 6);
            fill_rand(n);
            push_model(0, n);
            send_frame(0, n, 1);
        end

        // Reset in the middle of a frame
        fill_rand(8);
        beat(1, {fb[3], fb[2], fb[1], fb[0]}, 4'hF, 0, 0);
        beat(1, {fb[7], fb[6], fb[5], fb[4]}, 4'hF, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_str("123456789");
        push_exp(1, 32'hCBF43926, 0, 9);
        send_frame(1, 9, 1);

        gap(5);
        check("exp1_q_empty", exp1_q.size(), 0);
        check("exp4_q_empty", exp4_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
